// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, control states, shift kinds and operation helpers.
// Imported by seq_alu and seq_shifter.
package alu_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_XOR = 4'b0100,
      OP_SLL = 4'b0101,
      OP_SRL = 4'b0110,
      OP_SRA = 4'b0111,
      OP_BEQ = 4'b1000,
      OP_SLT = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shift_kind_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   function automatic shift_kind_e shift_kind_of(input logic [3:0] op);
      case (op)
         OP_SRL:  return SH_SRL;
         OP_SRA:  return SH_SRA;
         default: return SH_SLL;
      endcase
   endfunction

endpackage

// File: rtl/seq_shifter.sv
// Serial shifter: moves the operand one bit position per cycle while the counter is non-zero.
// i_start loads operand and count; o_last flags the cycle whose clock edge produces the final value.
module seq_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic                     i_flush,
   input  shift_kind_e              i_kind,
   input  logic [WIDTH-1:0]         i_dat,
   input  logic [$clog2(WIDTH)-1:0] i_amt,
   output logic                     o_busy,
   output logic                     o_last,
   output logic [WIDTH-1:0]         o_next
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] ONE = SHW'(1);

   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_dat;
   shift_kind_e      r_kind;
   logic [WIDTH-1:0] w_next;

   always_comb begin
      w_next = r_dat;
      case (r_kind)
         SH_SLL:  w_next = {r_dat[WIDTH-2:0], 1'b0};
         SH_SRL:  w_next = {1'b0, r_dat[WIDTH-1:1]};
         SH_SRA:  w_next = {r_dat[WIDTH-1], r_dat[WIDTH-1:1]};
         default: w_next = r_dat;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_dat  <= '0;
         r_kind <= SH_SLL;
      end else if (i_flush) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt  <= i_amt;
         r_dat  <= i_dat;
         r_kind <= i_kind;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - ONE;
         r_dat <= w_next;
      end
   end

   assign o_busy = (r_cnt != '0);
   assign o_last = (r_cnt == ONE);
   assign o_next = w_next;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops answer one cycle after accept, shifts take 1+n cycles.
// One request in flight; result held with out_valid until out_ready; flush aborts.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       Operation,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e       r_state;
   logic [WIDTH-1:0] r_result;

   logic             w_accept;
   logic             w_start;
   logic [SHW-1:0]   w_amt;
   logic [WIDTH-1:0] w_single;
   logic             w_sh_busy;
   logic             w_sh_last;
   logic [WIDTH-1:0] w_sh_next;

   // Shifts only reach here with a zero amount, so they pass SrcA through.
   function automatic logic [WIDTH-1:0] alu_single(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] res;
      res = '0;
      case (op)
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_ADD: res = a + b;
         OP_SUB: res = a - b;
         OP_XOR: res = a ^ b;
         OP_SLL: res = a;
         OP_SRL: res = a;
         OP_SRA: res = a;
         OP_BEQ: res = a - b;
         OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: res = '0;
      endcase
      return res;
   endfunction

   assign in_ready = (r_state == ST_IDLE) && !flush;
   assign w_accept = in_valid && in_ready;
   assign w_amt    = SrcB[SHW-1:0];
   assign w_start  = w_accept && is_shift_op(Operation) && (w_amt != '0);
   assign w_single = alu_single(Operation, SrcA, SrcB);

   seq_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start),
      .i_flush (flush),
      .i_kind  (shift_kind_of(Operation)),
      .i_dat   (SrcA),
      .i_amt   (w_amt),
      .o_busy  (w_sh_busy),
      .o_last  (w_sh_last),
      .o_next  (w_sh_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
      end else if (flush) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_start) begin
                     r_state <= ST_SHIFT;
                  end else begin
                     r_state  <= ST_DONE;
                     r_result <= w_single;
                  end
               end
            end
            ST_SHIFT: begin
               if (w_sh_last) begin
                  r_state  <= ST_DONE;
                  r_result <= w_sh_next;
               end else if (!w_sh_busy) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = (r_state == ST_DONE);
   assign ALUResult = r_result;
   assign Zero      = (r_result == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: cycle-stamped request model plus directed vectors with literal expectations.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic [3:0]  Operation = 4'h0;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic        in_ready;
   logic        out_valid;
   logic        Zero;
   logic [31:0] ALUResult;

   int errors = 0;
   int checks = 0;

   seq_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Zero      (Zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      int n;
      n = int'(b[4:0]);
      case (op)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a - b;
         4'd4: return a ^ b;
         4'd5: return a << n;
         4'd6: return a >> n;
         4'd7: return $signed(a) >>> n;
         4'd8: return a - b;
         4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
      return (op >= 4'd5 && op <= 4'd7) ? 1 + int'(b[4:0]) : 1;
   endfunction

   // Model: a pending request becomes visible at its cycle stamp and leaves on handshake or flush.
   int          cyc;
   bit          m_pend;
   int          m_valid_at;
   logic [31:0] m_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend <= 1'b0;
         cyc    <= 0;
      end else begin
         cyc <= cyc + 1;
         if (flush) begin
            m_pend <= 1'b0;
         end else if (m_pend) begin
            if (cyc >= m_valid_at && out_ready) m_pend <= 1'b0;
         end else if (in_valid) begin
            m_pend     <= 1'b1;
            m_valid_at <= cyc + exp_lat(Operation, SrcB);
            m_res      <= exp_result(Operation, SrcA, SrcB);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model in_ready", {31'd0, in_ready}, {31'd0, !m_pend && !flush});
         chk("model out_valid", {31'd0, out_valid}, {31'd0, m_pend && (cyc >= m_valid_at)});
         if (m_pend && cyc >= m_valid_at) begin
            chk("model ALUResult", ALUResult, m_res);
            chk("model Zero", {31'd0, Zero}, {31'd0, m_res == 32'd0});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
      SrcA      = $urandom;
      SrcB      = $urandom;
   endtask

   // Returns at the negedge of the first cycle showing out_valid.
   task automatic wait_valid(input string name, input int max, input int lat_exp,
                             input logic [31:0] res_exp);
      int  lat = 0;
      bit  seen = 0;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat  = i;
            seen = 1;
            break;
         end
         chk({name, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: out_valid not seen within %0d cycles", name, max);
      end else begin
         chk({name, " latency"}, lat, lat_exp);
         chk({name, " ALUResult"}, ALUResult, res_exp);
         chk({name, " Zero"}, {31'd0, Zero}, {31'd0, res_exp == 32'd0});
      end
   endtask

   logic [3:0]  t_op  [12] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h6, 4'h5, 4'h5, 4'h9, 4'h7, 4'hF, 4'h2, 4'h8};
   logic [31:0] t_a   [12] = '{32'hF0F0_1234, 32'h0000_00F0, 32'd3, 32'hAAAA_AAAA, 32'h8000_0000,
                               32'h0000_0001, 32'h1234_5678, 32'd3, 32'h4000_0000, 32'h1111_1111,
                               32'hFFFF_FFFF, 32'd10};
   logic [31:0] t_b   [12] = '{32'h0FF0_FFFF, 32'h0000_000F, 32'd5, 32'hFFFF_FFFF, 32'd4,
                               32'd31, 32'h0000_0020, 32'hFFFF_FFFB, 32'd2, 32'h2222_2222,
                               32'd1, 32'd3};
   logic [31:0] t_res [12] = '{32'h00F0_1234, 32'h0000_00FF, 32'hFFFF_FFFE, 32'h5555_5555,
                               32'h0800_0000, 32'h8000_0000, 32'h1234_5678, 32'd0,
                               32'h1000_0000, 32'd0, 32'd0, 32'd7};
   int          t_lat [12] = '{1, 1, 1, 1, 5, 32, 1, 1, 3, 1, 1, 1};

   initial begin
      #12;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset ALUResult", ALUResult, 32'd0);
      chk("reset Zero", {31'd0, Zero}, 32'd1);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);

      chk("pin sub wrap", exp_result(4'd3, 32'd5, 32'd7), 32'hFFFF_FFFE);
      chk("pin sra", exp_result(4'd7, 32'h8000_0000, 32'd31), 32'hFFFF_FFFF);
      chk("pin slt", exp_result(4'd9, 32'hFFFF_FFFB, 32'd3), 32'd1);
      chk("pin lat", exp_lat(4'd7, 32'd31), 32'd32);

      @(negedge clk);
      rst_n = 1'b1;
      issue(4'd2, 32'h7FFF_FFFF, 32'd1);
      wait_valid("add overflow", 5, 1, 32'h8000_0000);
      step();

      for (int i = 0; i < 12; i++) begin
         issue(t_op[i], t_a[i], t_b[i]);
         wait_valid($sformatf("vec%0d", i), 40, t_lat[i], t_res[i]);
         step();
      end

      issue(4'd7, 32'h8000_0000, 32'd31);
      wait_valid("sra31", 40, 32, 32'hFFFF_FFFF);
      step();

      out_ready = 1'b0;
      issue(4'd8, 32'h1234, 32'h1234);
      wait_valid("beq hold", 5, 1, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("beq held out_valid", {31'd0, out_valid}, 32'd1);
         chk("beq held ALUResult", ALUResult, 32'd0);
         chk("beq held Zero", {31'd0, Zero}, 32'd1);
      end
      step();
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("beq after handshake in_ready", {31'd0, in_ready}, 32'd1);
      chk("beq after handshake out_valid", {31'd0, out_valid}, 32'd0);
      step();

      issue(4'd5, 32'h0000_00FF, 32'd8);
      step();
      step();
      flush = 1'b1;
      @(negedge clk);
      chk("flush in_ready low", {31'd0, in_ready}, 32'd0);
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("after flush in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("after flush no out_valid", {31'd0, out_valid}, 32'd0);
      end
      step();
      issue(4'd9, 32'hFFFF_FFFB, 32'd3);
      wait_valid("slt after flush", 5, 1, 32'd1);
      step();

      flush     = 1'b1;
      in_valid  = 1'b1;
      Operation = 4'd2;
      SrcA      = 32'd1;
      SrcB      = 32'd1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush blocks accept", {31'd0, out_valid}, 32'd0);
      end
      step();

      out_ready = 1'b0;
      issue(4'd4, 32'h0000_000F, 32'h0000_00F0);
      wait_valid("xor flush+handshake", 5, 1, 32'h0000_00FF);
      step();
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      @(negedge clk);
      chk("flush+handshake out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush+handshake in_ready", {31'd0, in_ready}, 32'd1);
      step();

      issue(4'd5, 32'd1, 32'd20);
      step();
      step();
      #1;
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("async reset ALUResult", ALUResult, 32'd0);
      chk("async reset Zero", {31'd0, Zero}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         chk("no stale shift result", {31'd0, out_valid}, 32'd0);
      end
      issue(4'd5, 32'hDEAD_BEEF, 32'd0);
      wait_valid("sll zero after reset", 5, 1, 32'hDEAD_BEEF);
      step();

      out_ready = 1'b0;
      issue(4'd2, 32'd5, 32'd6);
      wait_valid("add before reset", 5, 1, 32'd11);
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset in DONE out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no result after DONE reset", {31'd0, out_valid}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
